// File: rtl/rll_key_loader_if.sv
// Valid/ready word stream carrying key words and the trailing checksum into rll_key_loader.
interface rll_key_loader_if #(
    parameter int unsigned WORD_WIDTH = 8
) ();
    logic                  word_valid;
    logic                  word_ready;
    logic [WORD_WIDTH-1:0] word_data;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/rll_key_loader.sv
// Key-provisioning controller: streams key words in, verifies an XOR checksum and only then
// drives the committed key onto the locked netlist; repeated bad loads lock it out until reset.
module rll_key_loader #(
    parameter int unsigned          KEY_WIDTH  = 32,
    parameter int unsigned          WORD_WIDTH = 8,
    parameter int unsigned          MAX_FAILS  = 3,
    parameter logic [KEY_WIDTH-1:0] DECOY      = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    rll_key_loader_if.slave        word_if,
    output logic [KEY_WIDTH-1:0]   key_out,
    output logic                   key_valid,
    output logic                   busy,
    output logic                   error,
    output logic                   locked_out
);

    localparam int unsigned NumWords = KEY_WIDTH / WORD_WIDTH;
    localparam int unsigned BeatW    = $clog2(NumWords + 1);
    localparam int unsigned FailW    = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StActive,
        StLockout
    } state_e;

    state_e                  state_q, state_d;
    logic [KEY_WIDTH-1:0]    shadow_q, shadow_d;
    logic [KEY_WIDTH-1:0]    key_reg_q, key_reg_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic [WORD_WIDTH-1:0]   xor_q, xor_d;
    logic [WORD_WIDTH-1:0]   csum_q, csum_d;
    logic [FailW-1:0]        fails_q, fails_d;
    logic                    check_pass;

    assign check_pass = (xor_q == csum_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            key_reg_q <= '0;
            beat_q    <= '0;
            xor_q     <= '0;
            csum_q    <= '0;
            fails_q   <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            key_reg_q <= key_reg_d;
            beat_q    <= beat_d;
            xor_q     <= xor_d;
            csum_q    <= csum_d;
            fails_q   <= fails_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        key_reg_d = key_reg_q;
        beat_d    = beat_q;
        xor_d     = xor_q;
        csum_d    = csum_q;
        fails_d   = fails_q;

        unique case (state_q)
            StIdle, StActive: begin
                if (start) begin
                    state_d = StLoad;
                    beat_d  = '0;
                    xor_d   = '0;
                end
            end
            StLoad: begin
                // word_ready is high for the whole of LOAD, so valid alone completes a beat
                if (word_if.word_valid) begin
                    if (beat_q == BeatW'(NumWords)) begin
                        csum_d  = word_if.word_data;
                        state_d = StCheck;
                    end else begin
                        for (int unsigned k = 0; k < NumWords; k++) begin
                            if (beat_q == BeatW'(k)) begin
                                shadow_d[k*WORD_WIDTH +: WORD_WIDTH] = word_if.word_data;
                            end
                        end
                        xor_d  = xor_q ^ word_if.word_data;
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                if (check_pass) begin
                    key_reg_d = shadow_q;
                    fails_d   = '0;
                    state_d   = StActive;
                end else begin
                    fails_d = fails_q + 1'b1;
                    state_d = (fails_d == FailW'(MAX_FAILS)) ? StLockout : StIdle;
                end
            end
            StLockout: begin
                state_d = StLockout;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode registered state only; nothing combinational from the inputs.
    assign word_if.word_ready = (state_q == StLoad);
    assign busy               = (state_q == StLoad) || (state_q == StCheck);
    assign error              = (state_q == StCheck) && !check_pass;
    assign key_valid          = (state_q == StActive);
    assign locked_out         = (state_q == StLockout);
    assign key_out            = key_valid ? key_reg_q : DECOY;

endmodule

// File: tb/tb_rll_key_loader.sv
// Randomized self-checking bench for rll_key_loader against a load-level behavioural model.
module tb_rll_key_loader;

    localparam int unsigned KW     = 32;
    localparam int unsigned WW     = 8;
    localparam int unsigned NW     = KW / WW;
    localparam int unsigned MAXF   = 3;
    localparam logic [KW-1:0] DEC  = 32'hA5C3_5A3C;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          busy;
    logic          error;
    logic          locked_out;

    int n_checks = 0;
    int n_errors = 0;

    // Model: committed key, whether it is shown, consecutive fails and lockout.
    logic [KW-1:0] m_key;
    bit            m_valid;
    int            m_fails;
    bit            m_locked;

    rll_key_loader_if #(.WORD_WIDTH(WW)) word_if ();

    rll_key_loader #(
        .KEY_WIDTH  (KW),
        .WORD_WIDTH (WW),
        .MAX_FAILS  (MAXF),
        .DECOY      (DEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_if    (word_if),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .error      (error),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] xor_of(input logic [KW-1:0] kw);
        logic [WW-1:0] x = '0;
        for (int i = 0; i < NW; i++) x ^= kw[i*WW +: WW];
        return x;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_key_valid"}, key_valid, m_valid);
        check({tag, "_key_out"}, key_out, m_valid ? m_key : DEC);
        check({tag, "_locked"}, locked_out, m_locked);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_ready"}, word_if.word_ready, 1'b0);
    endtask

    task automatic do_reset(input bit with_start);
        rst   = 1'b1;
        start = with_start;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        word_if.word_valid = 1'b0;
        m_valid  = 1'b0;
        m_fails  = 0;
        m_locked = 1'b0;
        check_quiet("reset");
    endtask

    // Full load: start, N data words (LSW first), checksum. gap_max bounds random stall cycles
    // before each beat; toggle forces exactly one idle cycle between beats.
    task automatic run_load(input logic [KW-1:0] kw, input logic [WW-1:0] cs,
                            input int gap_max, input bit toggle);
        int gap;
        bit pass;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (m_locked) begin
            for (int i = 0; i < 4; i++) begin
                check("locked_ready", word_if.word_ready, 1'b0);
                check("locked_key_out", key_out, DEC);
                check("locked_flag", locked_out, 1'b1);
                @(negedge clk);
            end
            return;
        end
        check("load_ready", word_if.word_ready, 1'b1);
        check("load_busy", busy, 1'b1);
        check("load_key_valid", key_valid, 1'b0);
        check("load_key_out", key_out, DEC);
        for (int b = 0; b <= NW; b++) begin
            gap = toggle ? 1 : $urandom_range(gap_max, 0);
            word_if.word_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                word_if.word_data = WW'($urandom);
                @(negedge clk);
                check("stall_ready", word_if.word_ready, 1'b1);
                check("stall_key_out", key_out, DEC);
            end
            word_if.word_valid = 1'b1;
            word_if.word_data  = (b < NW) ? kw[b*WW +: WW] : cs;
            @(negedge clk);
        end
        word_if.word_valid = 1'b0;
        word_if.word_data  = WW'($urandom);
        pass = (xor_of(kw) == cs);
        check("chk_busy", busy, 1'b1);
        check("chk_ready", word_if.word_ready, 1'b0);
        check("chk_error", error, !pass);
        check("chk_key_valid", key_valid, 1'b0);
        if (pass) begin
            m_key   = kw;
            m_valid = 1'b1;
            m_fails = 0;
        end else begin
            m_valid = 1'b0;
            m_fails++;
            if (m_fails == MAXF) m_locked = 1'b1;
        end
        @(negedge clk);
        check_quiet("done");
    endtask

    initial begin
        logic [KW-1:0] kw;
        logic [WW-1:0] cs;
        word_if.word_valid = 1'b0;
        word_if.word_data  = '0;
        m_key = '0;
        @(negedge clk);
        do_reset(1'b0);

        // Good load, then backpressured duplicate of it.
        run_load(32'hDEADBEEF, 8'h22, 0, 1'b0);
        check("good_key", key_out, 32'hDEADBEEF);
        run_load(32'hDEADBEEF, 8'h22, 0, 1'b1);
        check("bp_key", key_out, 32'hDEADBEEF);

        // Reload from ACTIVE.
        run_load(32'h04030201, 8'h04, 0, 1'b0);
        check("reload_key", key_out, 32'h04030201);

        // Bad checksum, then a pass clears the fail streak.
        run_load(32'hDEADBEEF, 8'h23, 0, 1'b0);
        run_load(32'hDEADBEEF, 8'h23, 0, 1'b0);
        run_load(32'hDEADBEEF, 8'h22, 0, 1'b0);
        run_load(32'hDEADBEEF, 8'h23, 0, 1'b0);
        run_load(32'hDEADBEEF, 8'h23, 0, 1'b0);
        check("no_accumulate", locked_out, 1'b0);

        // Third consecutive failure locks; a good load is then ignored.
        run_load(32'hDEADBEEF, 8'h23, 0, 1'b0);
        check("lockout", locked_out, 1'b1);
        run_load(32'hDEADBEEF, 8'h22, 0, 1'b0);
        do_reset(1'b0);

        // Reset mid-load (with start raised alongside), then a clean load.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        word_if.word_valid = 1'b1;
        word_if.word_data  = 8'h99;
        repeat (2) @(negedge clk);
        do_reset(1'b1);
        run_load(32'h12345678, xor_of(32'h12345678), 0, 1'b0);
        check("post_reset_key", key_out, 32'h12345678);

        // Randomized loads with mixed checksums and stalls.
        for (int t = 0; t < 40; t++) begin
            kw = KW'($urandom);
            cs = xor_of(kw);
            if ($urandom_range(2, 0) == 0) cs ^= WW'($urandom_range(255, 1));
            run_load(kw, cs, 3, 1'b0);
            if (m_locked && $urandom_range(1, 0) == 1) do_reset(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rll_key_loader.md
# rll_key_loader

Sequential key-provisioning controller for the random-logic-locked benchmark netlists. It receives the activation key as a stream of words over a valid/ready handshake and verifies a trailing XOR checksum. Only after a good checksum does it drive the full key onto the locked netlist's keyIn bus. Repeated bad loads trip a lockout that only reset clears.

## Interface
Parameters:
- KEY_WIDTH, 32, key bits driven to the locked netlist (keyIn_0_0..keyIn_0_31); must be a multiple of WORD_WIDTH
- WORD_WIDTH, 8, width of each streamed key word and of the checksum
- MAX_FAILS, 3, consecutive checksum failures before lockout (1..15)
- DECOY, 32'h0, value driven on key_out whenever key_valid is low

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a (re)load; sampled only in IDLE or ACTIVE
- word_valid  in  1  word_data holds a valid word
- word_ready  out  1  loader accepts a word this cycle
- word_data  in  WORD_WIDTH  key word (least-significant word first), then checksum word
- key_out  out  KEY_WIDTH  key to the locked netlist; bit i drives keyIn_0_i
- key_valid  out  1  key_out carries a verified key
- busy  out  1  high in LOAD and CHECK
- error  out  1  one-cycle pulse on checksum mismatch
- locked_out  out  1  lockout active; sticky until rst

## Operation
- N = KEY_WIDTH/WORD_WIDTH data words, followed by 1 checksum word. Total per load: N+1 beats.
- Checksum = XOR of all N data words.
- Registers:
  - shadow[KEY_WIDTH]: load target.
  - key_reg[KEY_WIDTH]: committed key. key_reg updates only on a pass, so a partial or failed load never reaches key_out.
  - beat counter: 0..N.
  - running XOR: WORD_WIDTH bits.
  - fail counter: 0..MAX_FAILS.
- States:
  - IDLE: word_ready=0. On start, go to LOAD; clear beat counter and running XOR.
  - LOAD: word_ready=1. A beat is accepted when word_valid&&word_ready.
    - Beat k<N: write shadow[k*WORD_WIDTH +: WORD_WIDTH]=word_data and fold word_data into the XOR.
    - Beat N: latch word_data as the checksum and go to CHECK.
    - word_valid low stalls indefinitely with no timeout.
    - start is ignored in LOAD.
  - CHECK (1 cycle): word_ready=0. Compare running XOR with the checksum.
    - Pass: key_reg<=shadow, fail counter<=0, go to ACTIVE.
    - Fail: error pulses for this cycle only, fail counter++. If the new count equals MAX_FAILS go to LOCKOUT, else go to IDLE.
  - ACTIVE: key_valid=1, key_out=key_reg. On start, go to LOAD. key_valid drops on the same edge, so key_out=DECOY throughout the reload.
  - LOCKOUT: locked_out=1, word_ready=0, key_valid=0, key_out=DECOY. start is ignored. Exit only via rst.
- key_out = key_valid ? key_reg : DECOY (registered outputs, no combinational path from inputs).
- Fail counter resets only on a pass or on rst. Non-consecutive failures separated by a pass do not accumulate.

## Timing
- Reset values: state=IDLE, word_ready=0, key_out=DECOY, key_valid=0, busy=0, error=0, locked_out=0. shadow, key_reg, counters and XOR all cleared.
- rst asserted in any state, including mid-LOAD or LOCKOUT, returns all of the above on the next edge. No partial key survives.
- Load latency:
  - start sampled high at edge t → word_ready=1 from cycle t+1.
  - Checksum accepted at edge c → CHECK during cycle c+1 → key_valid=1 and key_out=key from cycle c+2.
  - Minimum total: start to key_valid = N+3 cycles with word_valid held high.
- error is high for exactly the CHECK cycle of a failing load. locked_out rises at the following edge when the limit is reached.
- word_ready is a function of state only and never depends on word_valid.
- Simultaneous start and rst: rst wins.

## Test plan
- Good load: stream EF,BE,AD,DE then checksum 22 with word_valid held high. key_valid rises 2 cycles after the checksum beat; key_out=32'hDEADBEEF; error never asserts.
- Backpressure: same load with word_valid toggled every other cycle. Identical final key_out=32'hDEADBEEF; no beat is dropped or duplicated.
- Bad checksum: stream EF,BE,AD,DE then 23. error pulses for 1 cycle; state returns to IDLE; key_out stays DECOY; fail count=1.
- Lockout: three consecutive bad loads. locked_out=1 after the third. A subsequent start with a good load is ignored and word_ready stays 0. rst clears locked_out.
- Reload from ACTIVE: with key 0xDEADBEEF active, assert start. key_valid=0 and key_out=DECOY on the next cycle. Load 01,02,03,04 with checksum 04. key_out=32'h04030201.
- Reset mid-load: assert rst after 2 beats. All outputs return to reset values. A following full good load yields the correct key with no stale bytes.
